// File: rtl/data_memory_unit_if.sv
// Load/store request bus between the EX/MEM register and the MEM-stage data memory.
// The master drives the request; the slave returns stall, read data and status.
interface data_memory_unit_if;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [1:0]  size;
  logic        signed_load;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        stall_out;
  logic [31:0] read_data;
  logic        read_valid;
  logic        mem_error;

  modport master (
    output mem_read_enable, mem_write_enable, size, signed_load, addr, write_data,
    input  stall_out, read_data, read_valid, mem_error
  );

  modport slave (
    input  mem_read_enable, mem_write_enable, size, signed_load, addr, write_data,
    output stall_out, read_data, read_valid, mem_error
  );
endinterface

// File: rtl/data_memory_unit.sv
// MEM-stage data memory: byte-addressed little-endian storage with a fixed-latency
// IDLE/BUSY/DONE handshake. Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses.
module data_memory_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_unit_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] maddr_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        store_q;
  logic [1:0]  size_q;
  logic        signed_q;
  maddr_t      addr_q;
  logic [31:0] wdata_q;
  logic [31:0] read_data_q;
  logic        read_valid_q;
  logic        mem_error_q;
  logic        stall;

  logic [7:0]  mem [DEPTH];

  logic        req;
  logic        misaligned;
  logic        commit;
  maddr_t      a0, a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] load_value;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH];

  assign req = bus.mem_read_enable | bus.mem_write_enable;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = ((bus.size == 2'b01) && bus.addr[0]) ||
                      (bus.size[1] && (bus.addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign commit = (state_q == BUSY) && (cnt_q == 4'd0);

  // Byte lanes wrap naturally through the ADDR_WIDTH-bit sum.
  assign a0 = addr_q;
  assign a1 = addr_q + maddr_t'(1);
  assign a2 = addr_q + maddr_t'(2);
  assign a3 = addr_q + maddr_t'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    load_value = {b3, b2, b1, b0};
    case (size_q)
      2'b00:   load_value = {{24{signed_q & b0[7]}}, b0};
      2'b01:   load_value = {{16{signed_q & b1[7]}}, b1, b0};
      default: load_value = {b3, b2, b1, b0};
    endcase
  end

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = req;
        if (req) state_d = misaligned ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      store_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      read_data_q  <= 32'd0;
      read_valid_q <= 1'b0;
      mem_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_valid_q <= 1'b0;
      mem_error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            store_q  <= bus.mem_write_enable;
            size_q   <= bus.size;
            signed_q <= bus.signed_load;
            addr_q   <= bus.addr[ADDR_WIDTH-1:0];
            wdata_q  <= bus.write_data;
            cnt_q    <= 4'(LATENCY - 1);
            if (misaligned) begin
              mem_error_q <= 1'b1;
              read_data_q <= 32'd0;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            if (!store_q) begin
              read_data_q  <= load_value;
              read_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; a reset edge only blocks an uncommitted store.
  always_ff @(posedge clk) begin
    if (commit && store_q && !reset) begin
      mem[a0] <= wdata_q[7:0];
      if (size_q != 2'b00) mem[a1] <= wdata_q[15:8];
      if (size_q[1]) begin
        mem[a2] <= wdata_q[23:16];
        mem[a3] <= wdata_q[31:24];
      end
    end
  end

  assign bus.stall_out  = stall;
  assign bus.read_data  = read_data_q;
  assign bus.read_valid = read_valid_q;
  assign bus.mem_error  = mem_error_q;

endmodule
